interp8_14bit: RTL and testbench

- Linear interpolating upsampler, x8: the inverse-direction companion to the 8-sample averager (decimator) in the 14-bit sample path.
- Accepts one low-rate 14-bit unsigned sample per input handshake.
- Emits 8 evenly spaced samples from the previous sample toward the current sample.
- Sits between low-rate averaged/processed data and high-rate consumers (DAC feed, display sweep).

---
 rtl/interp8_pkg.sv | 33 +++
 rtl/interp_lerp_calc.sv | 38 +++
 rtl/interp8_14bit.sv | 99 +++++++++
 tb/tb_interp8_14bit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/interp8_pkg.sv
// Shared types and sizing helpers for the x8 linear interpolating upsampler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package interp8_pkg;

   localparam int DEF_WIDTH       = 14;
   localparam int DEF_LOG2_FACTOR = 3;

   typedef enum logic [1:0] {
      EMPTY,   // nothing held yet; next sample only primes
      WAIT,    // one sample held, waiting for the next to start a burst
      RUN      // emitting a burst of FACTOR outputs
   } state_t;

   function automatic int factor(input int log2_factor);
      return 1 << log2_factor;
   endfunction

   // C-P of two unsigned samples needs one extra bit for the sign.
   function automatic int diff_w(input int width);
      return width + 1;
   endfunction

   // diff * k, with k kept non-negative by a leading zero bit.
   function automatic int prod_w(input int width, input int log2_factor);
      return width + log2_factor + 2;
   endfunction

   function automatic int k_w(input int log2_factor);
      return log2_factor;
   endfunction

endpackage

// File: rtl/interp_lerp_calc.sv
// Combinational lerp: P + floor((C-P)*k / FACTOR).
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: p, c - endpoint samples; k - step index; lerp - interpolated sample.
module interp_lerp_calc
   import interp8_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int LOG2_FACTOR = DEF_LOG2_FACTOR
) (
   input  logic [WIDTH-1:0]       p,
   input  logic [WIDTH-1:0]       c,
   input  logic [LOG2_FACTOR-1:0] k,
   output logic [WIDTH-1:0]       lerp
);

   localparam int DIFF_W = diff_w(WIDTH);
   localparam int PROD_W = prod_w(WIDTH, LOG2_FACTOR);

   logic signed [DIFF_W-1:0] diff;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] shifted;
   logic        [DIFF_W-1:0] sum;
   logic                     lerp_unused;

   assign diff    = $signed({1'b0, c}) - $signed({1'b0, p});
   assign prod    = $signed({{(PROD_W-DIFF_W){diff[DIFF_W-1]}}, diff})
                  * $signed({{(PROD_W-LOG2_FACTOR){1'b0}}, k});
   // Arithmetic shift floors toward minus infinity for falling ramps.
   assign shifted = prod >>> LOG2_FACTOR;
   // The step never exceeds |C-P|, so the sum stays between P and C and the
   // upper bits are redundant.
   assign sum     = {1'b0, p} + shifted[DIFF_W-1:0];
   assign lerp    = sum[WIDTH-1:0];

   assign lerp_unused = ^{shifted[PROD_W-1:DIFF_W], sum[DIFF_W-1]};

endmodule

// File: rtl/interp8_14bit.sv
// x8 linear interpolating upsampler: 8 evenly spaced outputs from previous toward current sample.
// Latency: first output of a burst valid 1 cycle after the accepting edge; 1 output/cycle sustained.
// Backpressure: OUT_READY stalls the burst; IN_READY only opens on the last output of a burst.
// Ports: CLK, RST (async, active-high); DATA_IN/IN_VALID/IN_READY low-rate input;
//        DATA_OUT/OUT_VALID/OUT_READY high-rate registered output.
module interp8_14bit
   import interp8_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int LOG2_FACTOR = DEF_LOG2_FACTOR
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] DATA_OUT,
   output logic             OUT_VALID,
   input  logic             OUT_READY
);

   localparam int                   KW    = k_w(LOG2_FACTOR);
   localparam logic [KW-1:0]        K_ONE = KW'(1);

   state_t           state;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] c;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] lerp_next;
   logic             last;

   assign last = &k;   // k == FACTOR-1

   // Combinational from OUT_READY so a new sample lands on the same edge as
   // the last output of the burst, keeping the stream gapless.
   assign IN_READY = (state != RUN) | (last & OUT_READY);

   interp_lerp_calc #(
      .WIDTH       (WIDTH),
      .LOG2_FACTOR (LOG2_FACTOR)
   ) u_lerp (
      .p    (p),
      .c    (c),
      .k    (k + K_ONE),
      .lerp (lerp_next)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= EMPTY;
         p         <= '0;
         c         <= '0;
         k         <= '0;
         DATA_OUT  <= '0;
         OUT_VALID <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (IN_VALID) begin
                  p     <= DATA_IN;
                  c     <= DATA_IN;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (IN_VALID) begin
                  p         <= c;
                  c         <= DATA_IN;
                  k         <= '0;
                  DATA_OUT  <= c;   // k=0 output is exactly the old endpoint
                  OUT_VALID <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (OUT_READY) begin
                  if (!last) begin
                     k        <= k + K_ONE;
                     DATA_OUT <= lerp_next;
                  end else if (IN_VALID) begin
                     p         <= c;
                     c         <= DATA_IN;
                     k         <= '0;
                     DATA_OUT  <= c;
                  end else begin
                     OUT_VALID <= 1'b0;
                     state     <= WAIT;
                  end
               end
            end
            default: begin
               state     <= EMPTY;
               OUT_VALID <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interp8_14bit.sv
module tb_interp8_14bit;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [13:0] DATA_IN = '0;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic [13:0] DATA_OUT;
   logic        OUT_VALID;
   logic        OUT_READY = 1'b0;

   interp8_14bit dut (
      .CLK       (CLK),
      .RST       (RST),
      .DATA_IN   (DATA_IN),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .DATA_OUT  (DATA_OUT),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int prime;
      int s;
      int e[8];
   } vec_t;

   vec_t tbl[4];

   int n_chk = 0;
   int n_pass = 0;
   int expq[$];
   int got[$];
   int got_cyc[$];
   int cyc_n = 0;
   bit primed = 0;
   int prev_s = 0;
   bit stall_prev = 0;
   int stall_dat = 0;
   bit in_fire = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: P + floor((C-P)*k/8) using plain integer arithmetic.
   function automatic int lerp_ref(input int pv, input int cv, input int kv);
      int d;
      int q;
      d = (cv - pv) * kv;
      if (d >= 0) q = d / 8;
      else        q = -((-d + 7) / 8);
      return pv + q;
   endfunction

   task automatic model_accept(input int s);
      if (!primed) begin
         primed = 1;
         prev_s = s;
      end else begin
         for (int i = 0; i < 8; i++) expq.push_back(lerp_ref(prev_s, s, i));
         prev_s = s;
      end
   endtask

   // Drive one cycle; inputs change after the falling edge, everything is
   // sampled 1ns later and describes the handshake at the next rising edge.
   task automatic cyc(input bit iv, input int d, input bit ordy);
      int exp_rdy;
      @(negedge CLK);
      IN_VALID  = iv;
      DATA_IN   = d[13:0];
      OUT_READY = ordy;
      #1;
      cyc_n++;
      chk("out_valid", int'(OUT_VALID), (expq.size() > 0) ? 1 : 0);
      if (expq.size() == 0)      exp_rdy = 1;
      else if (expq.size() == 1) exp_rdy = ordy ? 1 : 0;
      else                       exp_rdy = 0;
      chk("in_ready", int'(IN_READY), exp_rdy);
      if (stall_prev) begin
         chk("stall_hold_valid", int'(OUT_VALID), 1);
         chk("stall_hold_data", int'(DATA_OUT), stall_dat);
      end
      stall_prev = OUT_VALID && !OUT_READY;
      stall_dat  = int'(DATA_OUT);
      if (OUT_VALID && OUT_READY) begin
         got.push_back(int'(DATA_OUT));
         got_cyc.push_back(cyc_n);
         if (expq.size() == 0) chk("unexpected_output", int'(DATA_OUT), -1);
         else                  chk("data_out", int'(DATA_OUT), expq.pop_front());
      end
      in_fire = iv && IN_READY;
      if (in_fire) model_accept(d);
   endtask

   task automatic drain(input bit rnd, input int maxc);
      int n;
      n = 0;
      while ((expq.size() > 0 || OUT_VALID) && n < maxc) begin
         cyc(0, 0, rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
         n++;
      end
      if (n >= maxc) chk("drain_timeout", n, 0);
   endtask

   // Asserts RST away from any clock edge and checks the immediate clear.
   task automatic do_reset();
      @(negedge CLK);
      #2;
      RST = 1'b1;
      #1;
      chk("reset_out_valid", int'(OUT_VALID), 0);
      chk("reset_data_out", int'(DATA_OUT), 0);
      expq.delete();
      primed     = 0;
      stall_prev = 0;
      IN_VALID   = 1'b0;
      OUT_READY  = 1'b0;
      @(negedge CLK);
      #1;
      chk("reset_in_ready", int'(IN_READY), 1);
      RST = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int vals[4];
      int idx;
      int n;
      int span;

      tbl[0].prime = 100;   tbl[0].s = 900;
      tbl[0].e = '{100, 200, 300, 400, 500, 600, 700, 800};
      tbl[1].prime = 10;    tbl[1].s = 3;
      tbl[1].e = '{10, 9, 8, 7, 6, 5, 4, 3};
      tbl[2].prime = 0;     tbl[2].s = 16383;
      tbl[2].e = '{0, 2047, 4095, 6143, 8191, 10239, 12287, 14335};
      tbl[3].prime = 16383; tbl[3].s = 16383;
      tbl[3].e = '{16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383};

      repeat (2) @(negedge CLK);
      do_reset();

      // Table vectors: prime, idle, send, collect one burst.
      for (int r = 0; r < 4; r++) begin
         do_reset();
         got.delete();
         cyc(1, tbl[r].prime, 1);
         cyc(0, 0, 1);
         cyc(0, 0, 1);
         cyc(1, tbl[r].s, 1);
         drain(0, 20);
         chk($sformatf("tbl%0d_count", r), got.size(), 8);
         for (int i = 0; i < 8 && i < got.size(); i++)
            chk($sformatf("tbl%0d_k%0d", r, i), got[i], tbl[r].e[i]);
      end

      // Gapless streaming with IN_VALID held high.
      do_reset();
      vals = '{0, 800, 0, 800};
      idx = 0;
      n = 0;
      got.delete();
      got_cyc.delete();
      while (idx < 4 && n < 100) begin
         cyc(1, vals[idx], 1);
         if (in_fire) idx++;
         n++;
      end
      chk("gapless_accepts", idx, 4);
      drain(0, 40);
      chk("gapless_count", got.size(), 24);
      span = (got.size() >= 24) ? got_cyc[23] - got_cyc[0] : -1;
      chk("gapless_span", span, 23);

      // Random OUT_READY stalls during a 100->900 burst.
      do_reset();
      got.delete();
      cyc(1, 100, 1);
      cyc(1, 900, 0);
      drain(1, 300);
      chk("stall_count", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++)
         chk($sformatf("stall_k%0d", i), got[i], tbl[0].e[i]);

      // Reset mid-burst at k=4, then prime and a fresh burst.
      do_reset();
      got.delete();
      cyc(1, 100, 1);
      cyc(1, 900, 1);
      n = 0;
      while (got.size() < 4 && n < 20) begin
         cyc(0, 0, 1);
         n++;
      end
      chk("midrun_fired", got.size(), 4);
      do_reset();
      got.delete();
      cyc(1, 50, 1);
      repeat (3) cyc(0, 0, 1);
      chk("post_reset_primed_only", got.size(), 0);
      cyc(1, 850, 1);
      drain(0, 20);
      chk("post_reset_count", got.size(), 8);
      chk("post_reset_first", (got.size() > 0) ? got[0] : -1, 50);
      chk("post_reset_last", (got.size() > 7) ? got[7] : -1, 750);

      // Random traffic against the reference model.
      do_reset();
      for (int i = 0; i < 1500; i++)
         cyc($urandom_range(0, 2) == 0, $urandom_range(0, 16383), $urandom_range(0, 3) != 0);
      drain(0, 40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
